// File: rtl/processorc_boot_pkg.sv
// Shared widths and state encoding for the flash-ROM boot copier.
package processorc_boot_pkg;

    localparam int unsigned ROM_ADDR_W = 10;
    localparam int unsigned ROM_DATA_W = 16;
    // One extra bit so a full 1024-word copy terminates without wrapping.
    localparam int unsigned WORD_CNT_W = ROM_ADDR_W + 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } boot_state_t;

endpackage

// File: rtl/flashrom_bootloader.sv
// Copies COPY_LENGTH words from a combinational ROM into instruction RAM after
// reset (or on StartBoot), holding the CPU core stalled until the copy ends.
module flashrom_bootloader
    import processorc_boot_pkg::*;
#(
    parameter int unsigned COPY_LENGTH = 24
) (
    input  logic                  clk,
    input  logic                  sync_rst,
    input  logic                  StartBoot,
    output logic [ROM_ADDR_W-1:0] RomAddress,
    input  logic [ROM_DATA_W-1:0] RomValue,
    output logic                  WriteValid,
    input  logic                  WriteReady,
    output logic [ROM_ADDR_W-1:0] WriteAddress,
    output logic [ROM_DATA_W-1:0] WriteData,
    output logic                  CoreHold,
    output logic                  BootDone
);

    localparam logic [WORD_CNT_W-1:0] LAST_COUNT = WORD_CNT_W'(COPY_LENGTH);

    boot_state_t           state_q, state_d;
    logic [WORD_CNT_W-1:0] word_count_q, word_count_d;
    logic [ROM_ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [ROM_DATA_W-1:0] write_data_q, write_data_d;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q      <= LOAD;
            word_count_q <= '0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        case (state_q)
            LOAD: begin
                write_data_d = RomValue;
                write_addr_d = word_count_q[ROM_ADDR_W-1:0];
                state_d      = SEND;
            end
            SEND: begin
                if (WriteReady) begin
                    word_count_d = word_count_q + WORD_CNT_W'(1);
                    state_d      = (word_count_d == LAST_COUNT) ? DONE : LOAD;
                end
            end
            DONE: begin
                if (StartBoot) begin
                    word_count_d = '0;
                    state_d      = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Control outputs decode straight from the state register.
    assign RomAddress   = word_count_q[ROM_ADDR_W-1:0];
    assign WriteValid   = (state_q == SEND);
    assign CoreHold     = (state_q != DONE);
    assign BootDone     = (state_q == DONE);
    assign WriteAddress = write_addr_q;
    assign WriteData    = write_data_q;

endmodule

// File: tb/tb_flashrom_bootloader.sv
// Bench for flashrom_bootloader: three instances (24, 1024 and 1 word copies).
module tb_flashrom_bootloader;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst   [NI];
    logic        start [NI];
    logic        ready [NI];
    logic [9:0]  ra    [NI];
    logic [15:0] rv    [NI];
    logic        wv    [NI];
    logic [9:0]  wa    [NI];
    logic [15:0] wd    [NI];
    logic        ch    [NI];
    logic        bd    [NI];

    typedef struct packed {
        logic [9:0]  a;
        logic [15:0] d;
    } wr_t;

    logic [15:0] rom_mem [1024];
    wr_t         wq [$];
    int          tick = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rv[0] = rom_mem[ra[0]];
    assign rv[1] = rom_mem[ra[1]];
    assign rv[2] = rom_mem[ra[2]];

    flashrom_bootloader #(.COPY_LENGTH(24)) dut (
        .clk(clk), .sync_rst(rst[0]), .StartBoot(start[0]), .RomAddress(ra[0]),
        .RomValue(rv[0]), .WriteValid(wv[0]), .WriteReady(ready[0]),
        .WriteAddress(wa[0]), .WriteData(wd[0]), .CoreHold(ch[0]), .BootDone(bd[0])
    );

    flashrom_bootloader #(.COPY_LENGTH(1024)) dut_big (
        .clk(clk), .sync_rst(rst[1]), .StartBoot(start[1]), .RomAddress(ra[1]),
        .RomValue(rv[1]), .WriteValid(wv[1]), .WriteReady(ready[1]),
        .WriteAddress(wa[1]), .WriteData(wd[1]), .CoreHold(ch[1]), .BootDone(bd[1])
    );

    flashrom_bootloader #(.COPY_LENGTH(1)) dut_one (
        .clk(clk), .sync_rst(rst[2]), .StartBoot(start[2]), .RomAddress(ra[2]),
        .RomValue(rv[2]), .WriteValid(wv[2]), .WriteReady(ready[2]),
        .WriteAddress(wa[2]), .WriteData(wd[2]), .CoreHold(ch[2]), .BootDone(bd[2])
    );

    // Scoreboard capture: every accepted RAM write of any active instance.
    always @(posedge clk) begin
        tick <= tick + 1;
        for (int u = 0; u < NI; u++)
            if (!rst[u] && wv[u] && ready[u])
                wq.push_back('{a: wa[u], d: wd[u]});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves instance u at cycle 0 (first LOAD); r is the tick of that cycle.
    task automatic release_rst(input int u, output int r);
        rst[u] = 1'b1;
        start[u] = 1'b0;
        step();
        step();
        rst[u] = 1'b0;
        wq.delete();
        r = tick;
    endtask

    task automatic wait_done(input int u, input int r, input int budget, output int dc);
        dc = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (bd[u]) begin
                dc = tick - r;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst[0] = 1'b1;
        step();
        step();
        checks++;
        if (wv[0] !== 1'b0 || ch[0] !== 1'b1 || bd[0] !== 1'b0 || ra[0] !== 10'h000) begin
            errors++;
            $display("FAIL reset_ctrl: wv=%b ch=%b bd=%b ra=%h, want 0 1 0 000", wv[0], ch[0], bd[0], ra[0]);
        end
        checks++;
        if (wa[0] !== 10'h000 || wd[0] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_regs: wa=%h wd=%h, want 000 0000", wa[0], wd[0]);
        end
    endtask

    task automatic test_basic_copy();
        int r, dc;
        logic pch, pbd;
        release_rst(0, r);
        ready[0] = 1'b1;
        checks++;
        if (wv[0] !== 1'b0 || ch[0] !== 1'b1 || bd[0] !== 1'b0 || ra[0] !== 10'h000) begin
            errors++;
            $display("FAIL v1_cycle0: wv=%b ch=%b bd=%b ra=%h, want 0 1 0 000", wv[0], ch[0], bd[0], ra[0]);
        end
        dc = -1;
        pch = ch[0];
        pbd = bd[0];
        for (int k = 0; k < 200; k++) begin
            step();
            if (bd[0]) begin
                dc = tick - r;
                break;
            end
            pch = ch[0];
            pbd = bd[0];
        end
        checks++;
        if (dc !== 48) begin
            errors++;
            $display("FAIL v1_done_cycle: got %0d want 48", dc);
        end
        checks++;
        if (ch[0] !== 1'b0 || pch !== 1'b1 || pbd !== 1'b0) begin
            errors++;
            $display("FAIL v1_corehold_edge: ch=%b prev_ch=%b prev_bd=%b, want 0 1 0", ch[0], pch, pbd);
        end
        checks++;
        if (wq.size() !== 24) begin
            errors++;
            $display("FAIL v1_write_count: got %0d want 24", wq.size());
        end
        for (int i = 0; i < wq.size(); i++) begin
            checks++;
            if (wq[i].a !== 10'(i) || wq[i].d !== rom_mem[i]) begin
                errors++;
                $display("FAIL v1_write[%0d]: got %h/%h want %h/%h", i, wq[i].a, wq[i].d, 10'(i), rom_mem[i]);
            end
        end
    endtask

    task automatic test_stall();
        int r, dc, n7;
        bit stalled;
        release_rst(0, r);
        ready[0] = 1'b1;
        stalled = 1'b0;
        dc = -1;
        for (int k = 0; k < 200; k++) begin
            step();
            if (bd[0]) begin
                dc = tick - r;
                break;
            end
            if (!stalled && wv[0] && wa[0] == 10'd7) begin
                ready[0] = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    checks++;
                    if (wv[0] !== 1'b1 || wa[0] !== 10'd7 || wd[0] !== rom_mem[7]) begin
                        errors++;
                        $display("FAIL v2_hold[%0d]: wv=%b wa=%h wd=%h want 1 007 %h", s, wv[0], wa[0], wd[0], rom_mem[7]);
                    end
                    step();
                end
                ready[0] = 1'b1;
                stalled = 1'b1;
            end
        end
        n7 = 0;
        foreach (wq[i]) if (wq[i].a == 10'd7) n7++;
        checks++;
        if (n7 !== 1 || wq.size() !== 24) begin
            errors++;
            $display("FAIL v2_writes: addr7 writes=%0d total=%0d want 1 24", n7, wq.size());
        end
        checks++;
        if (dc !== 53) begin
            errors++;
            $display("FAIL v2_done_cycle: got %0d want 53", dc);
        end
    endtask

    task automatic test_startboot();
        int r, dc;
        bit pulsed;
        release_rst(0, r);
        ready[0] = 1'b1;
        pulsed = 1'b0;
        dc = -1;
        for (int k = 0; k < 200; k++) begin
            step();
            if (bd[0]) begin
                dc = tick - r;
                break;
            end
            if (!pulsed && ra[0] == 10'd10) begin
                start[0] = 1'b1;
                step();
                start[0] = 1'b0;
                pulsed = 1'b1;
            end
        end
        checks++;
        if (dc !== 48 || wq.size() !== 24) begin
            errors++;
            $display("FAIL v3_ignored_start: done=%0d writes=%0d want 48 24", dc, wq.size());
        end
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (bd[0] !== 1'b1 || wq.size() !== 24) begin
            errors++;
            $display("FAIL v3_done_hold: bd=%b writes=%0d want 1 24", bd[0], wq.size());
        end
        wq.delete();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        r = tick;
        checks++;
        if (ch[0] !== 1'b1 || bd[0] !== 1'b0 || ra[0] !== 10'h000 || wv[0] !== 1'b0) begin
            errors++;
            $display("FAIL v3_restart: ch=%b bd=%b ra=%h wv=%b want 1 0 000 0", ch[0], bd[0], ra[0], wv[0]);
        end
        wait_done(0, r, 200, dc);
        checks++;
        if (dc !== 48 || wq.size() !== 24) begin
            errors++;
            $display("FAIL v3_recopy: done=%0d writes=%0d want 48 24", dc, wq.size());
        end
        for (int i = 0; i < wq.size(); i++) begin
            checks++;
            if (wq[i].a !== 10'(i) || wq[i].d !== rom_mem[i]) begin
                errors++;
                $display("FAIL v3_write[%0d]: got %h/%h want %h/%h", i, wq[i].a, wq[i].d, 10'(i), rom_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int r, dc;
        bit hit;
        release_rst(0, r);
        ready[0] = 1'b1;
        hit = 1'b0;
        dc = -1;
        for (int k = 0; k < 300; k++) begin
            step();
            if (bd[0]) begin
                dc = tick - r;
                break;
            end
            if (!hit && wv[0] && wa[0] == 10'd12) begin
                rst[0] = 1'b1;
                step();
                rst[0] = 1'b0;
                hit = 1'b1;
                checks++;
                if (wv[0] !== 1'b0 || ra[0] !== 10'h000 || ch[0] !== 1'b1 || bd[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL v4_after_rst: wv=%b ra=%h ch=%b bd=%b want 0 000 1 0", wv[0], ra[0], ch[0], bd[0]);
                end
                checks++;
                if (wq.size() !== 12) begin
                    errors++;
                    $display("FAIL v4_pre_rst_writes: got %0d want 12", wq.size());
                end
                wq.delete();
                r = tick;
            end
        end
        checks++;
        if (dc !== 48 || wq.size() !== 24) begin
            errors++;
            $display("FAIL v4_recopy: done=%0d writes=%0d want 48 24", dc, wq.size());
        end
        for (int i = 0; i < wq.size(); i++) begin
            checks++;
            if (wq[i].a !== 10'(i) || wq[i].d !== rom_mem[i]) begin
                errors++;
                $display("FAIL v4_write[%0d]: got %h/%h want %h/%h", i, wq[i].a, wq[i].d, 10'(i), rom_mem[i]);
            end
        end
    endtask

    // Random ready/StartBoot: each word costs 2 cycles plus every refused SEND cycle.
    task automatic test_random();
        int r, dc, stalls;
        release_rst(0, r);
        stalls = 0;
        dc = -1;
        for (int k = 0; k < 1000; k++) begin
            step();
            checks++;
            if (ch[0] !== ~bd[0]) begin
                errors++;
                $display("FAIL rnd_hold_vs_done: ch=%b bd=%b", ch[0], bd[0]);
            end
            if (bd[0]) begin
                dc = tick - r;
                break;
            end
            ready[0] = ($urandom_range(0, 2) != 0);
            start[0] = ($urandom_range(0, 7) == 0);
            if (wv[0] && !ready[0]) stalls++;
        end
        start[0] = 1'b0;
        checks++;
        if (dc !== 48 + stalls) begin
            errors++;
            $display("FAIL rnd_done_cycle: got %0d want %0d", dc, 48 + stalls);
        end
        checks++;
        if (wq.size() !== 24) begin
            errors++;
            $display("FAIL rnd_write_count: got %0d want 24", wq.size());
        end
        for (int i = 0; i < wq.size(); i++) begin
            checks++;
            if (wq[i].a !== 10'(i) || wq[i].d !== rom_mem[i]) begin
                errors++;
                $display("FAIL rnd_write[%0d]: got %h/%h want %h/%h", i, wq[i].a, wq[i].d, 10'(i), rom_mem[i]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            ready[0] = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (bd[0] !== 1'b1 || wv[0] !== 1'b0) begin
                errors++;
                $display("FAIL rnd_done_idle: bd=%b wv=%b want 1 0", bd[0], wv[0]);
            end
        end
        checks++;
        if (wq.size() !== 24) begin
            errors++;
            $display("FAIL rnd_ready_in_done: writes=%0d want 24", wq.size());
        end
    endtask

    task automatic test_long_copy();
        int r, dc, n0;
        release_rst(1, r);
        ready[1] = 1'b1;
        wait_done(1, r, 2200, dc);
        checks++;
        if (dc !== 2048) begin
            errors++;
            $display("FAIL v5_done_cycle: got %0d want 2048", dc);
        end
        checks++;
        if (wq.size() !== 1024) begin
            errors++;
            $display("FAIL v5_write_count: got %0d want 1024", wq.size());
        end
        n0 = 0;
        foreach (wq[i]) if (wq[i].a == 10'h000) n0++;
        checks++;
        if (n0 !== 1) begin
            errors++;
            $display("FAIL v5_addr0_writes: got %0d want 1", n0);
        end
        if (wq.size() > 0) begin
            checks++;
            if (wq[wq.size()-1].a !== 10'h3FF) begin
                errors++;
                $display("FAIL v5_last_addr: got %h want 3ff", wq[wq.size()-1].a);
            end
        end
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i].a !== 10'(i) || wq[i].d !== rom_mem[i]) begin
                checks++;
                errors++;
                $display("FAIL v5_write[%0d]: got %h/%h want %h/%h", i, wq[i].a, wq[i].d, 10'(i), rom_mem[i]);
            end
        end
    endtask

    task automatic test_single_word();
        int r, dc;
        release_rst(2, r);
        ready[2] = 1'b1;
        wait_done(2, r, 50, dc);
        checks++;
        if (dc !== 2) begin
            errors++;
            $display("FAIL v6_done_cycle: got %0d want 2", dc);
        end
        checks++;
        if (wq.size() !== 1) begin
            errors++;
            $display("FAIL v6_write_count: got %0d want 1", wq.size());
        end else begin
            checks++;
            if (wq[0].a !== 10'h000 || wq[0].d !== rom_mem[0]) begin
                errors++;
                $display("FAIL v6_write: got %h/%h want 000/%h", wq[0].a, wq[0].d, rom_mem[0]);
            end
        end
    endtask

    initial begin
        for (int u = 0; u < NI; u++) begin
            rst[u]   = 1'b1;
            start[u] = 1'b0;
            ready[u] = 1'b0;
        end
        for (int i = 0; i < 1024; i++) rom_mem[i] = 16'($urandom);
        rom_mem[0]  = 16'hD188;
        rom_mem[23] = 16'hA00F;

        test_reset();
        test_basic_copy();
        test_stall();
        test_startboot();
        test_reset_mid();
        test_random();
        test_long_copy();
        test_single_word();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flashrom_bootloader.md
FLASHROM_BOOTLOADER -- requirements
Module: flashrom_bootloader

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, sync_rst.
REQ-002 Parameter COPY_LENGTH SHALL default to 24 and SHALL mean the number of ROM words copied per boot (legal range 1..1024).
REQ-003 Port list, with name, direction, width and meaning:
- clk  in  1  clock
- sync_rst  in  1  synchronous active-high reset
- StartBoot  in  1  single-cycle request to re-run the copy
- RomAddress  out  10  address to the combinational instruction ROM
- RomValue  in  16  ROM data for RomAddress, valid in the same cycle
- WriteValid  out  1  instruction-RAM write request
- WriteReady  in  1  instruction RAM accepts the write
- WriteAddress  out  10  instruction-RAM word address
- WriteData  out  16  instruction word
- CoreHold  out  1  holds the CPU core stalled while high
- BootDone  out  1  copy complete

Function
REQ-004 The FSM SHALL have three states: LOAD, SEND and DONE.
REQ-005 The block SHALL hold an 11-bit word counter WordCount.
- RomAddress SHALL equal WordCount[9:0] in every state.
REQ-006 LOAD: on the next edge, register RomValue into WriteData and WordCount[9:0] into WriteAddress, then enter SEND. LOAD SHALL last exactly one cycle.
REQ-007 SEND: WriteValid SHALL be 1. WriteAddress and WriteData SHALL stay stable until a handshake (WriteValid and WriteReady both 1 at a rising edge).
REQ-008 On a SEND handshake, WordCount SHALL increment.
- Next state SHALL be DONE if WordCount+1 == COPY_LENGTH, else LOAD.
REQ-009 When WriteReady is held high, throughput SHALL be one word per 2 cycles. A full copy SHALL take 2*COPY_LENGTH cycles from the first LOAD to DONE.
REQ-010 In DONE: WriteValid=0, CoreHold=0, BootDone=1, and WordCount SHALL hold its value.
REQ-011 StartBoot in DONE SHALL, on the next edge:
- clear WordCount
- set CoreHold=1 and BootDone=0
- enter LOAD.
REQ-012 StartBoot in LOAD or SEND SHALL be ignored; the copy in progress SHALL continue unchanged.
REQ-013 WriteReady while WriteValid=0 SHALL be ignored.
REQ-014 CoreHold SHALL be 1 in LOAD and SEND, and SHALL fall in the same cycle BootDone rises.
REQ-015 With COPY_LENGTH=1024:
- the last address SHALL be 10'h3FF
- termination SHALL be decided by the 11-bit compare, so RomAddress never wraps to 0 during the copy.
REQ-016 CoreHold, BootDone and WriteValid SHALL be decoded directly from the state register, with no combinational path from any input.

Reset
REQ-017 While sync_rst is high, at each edge the block SHALL set: state=LOAD, WordCount=0, WriteAddress=0, WriteData=16'h0000.
REQ-018 Output values during and after reset SHALL be: WriteValid=0, CoreHold=1, BootDone=0, RomAddress=0.
REQ-019 Reset asserted mid-copy SHALL abandon the copy; the first cycle after reset deasserts SHALL be LOAD at address 0.
REQ-020 The copy SHALL start automatically after reset, without StartBoot.

Structure
REQ-021 Package processorc_boot_pkg SHALL hold:
- ROM_ADDR_W=10 and ROM_DATA_W=16
- the state enum boot_state_t {LOAD, SEND, DONE}.
REQ-022 The block SHALL need no sub-module; the counter and FSM are inline.
REQ-023 The ROM and the instruction RAM SHALL be instantiated by the parent.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- V1: Setup: COPY_LENGTH=24, WriteReady=1, ROM model (addr 0 -> 16'hD188, addr 23 -> 16'hA00F). Stimulus: release reset. Required: 24 writes to addresses 0..23 with matching data; BootDone rises at cycle 48; CoreHold falls in that same cycle.
- V2: Stimulus: WriteReady held low for 5 cycles during the word at addr 7. Required: WriteValid stays 1, and WriteAddress=7 and WriteData are stable throughout; exactly one write to addr 7.
- V3: Stimulus: StartBoot pulse at addr 10 mid-copy. Required: ignored; copy completes normally. Stimulus: StartBoot pulse in DONE. Required: next cycle CoreHold=1, BootDone=0, RomAddress=0; full copy repeats.
- V4: Stimulus: sync_rst asserted 1 cycle while in SEND at addr 12. Required: WriteValid=0 next cycle, then the copy restarts at addr 0.
- V5: Setup: COPY_LENGTH=1024, WriteReady=1. Required: the last write is at 10'h3FF; BootDone at cycle 2048; no write to addr 0 after the first.
- V6: Setup: COPY_LENGTH=1. Required: single write to addr 0; BootDone at cycle 2.
